// File: rtl/lane_spawn_pkg.sv
// Shared types and constants for the lane spawn sequencer.
package lane_spawn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_MASK        = 16'hB400;
  localparam logic [2:0]  MAX_SPEED        = 3'd7;
  localparam int          MAX_CARS_DEFAULT = 5;

endpackage

// File: rtl/lane_spawn_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR; shifts right, taps applied when bit 0 falls out.
module lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1,
  parameter logic [15:0] Mask = 16'hB400
) (
  input  logic        Clk,
  input  logic        ResetN,
  output logic [15:0] Q
);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Q <= Seed;
    end else begin
      Q <= {1'b0, Q[15:1]} ^ (Q[0] ? Mask : 16'h0000);
    end
  end

endmodule

// File: rtl/lane_spawn_sequencer.sv
// Walks every lane on a level start: loads a random per-lane config on shared
// buses one cycle ahead of that lane's SpawnEnable strobe.
module lane_spawn_sequencer
  import lane_spawn_pkg::*;
#(
  parameter int          NumLanes = 8,
  parameter int          PulseLen = 2,
  parameter logic [15:0] Seed     = 16'hACE1,
  parameter int          MaxCars  = MAX_CARS_DEFAULT
) (
  input  logic                Clk,
  input  logic                ResetN,
  input  logic                LevelStart,
  input  logic [2:0]          Level,
  output logic [NumLanes-1:0] SpawnEnable,
  output logic                Direction,
  output logic [1:0]          CarType,
  output logic [2:0]          CarCount,
  output logic [2:0]          CarSpeed,
  output logic                Busy,
  output logic                Done,
  output state_t              DbgState
);

  localparam int          IdxW      = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam logic [IdxW-1:0] LAST_LANE = IdxW'(NumLanes - 1);
  localparam logic [2:0]  PULSE_INIT = 3'(PulseLen - 1);
  localparam logic [3:0]  MAX_CARS4  = 4'(MaxCars);
  localparam logic [2:0]  MAX_CARS3  = 3'(MaxCars);

  state_t          state, state_n;
  logic [IdxW-1:0] idx, idx_n;
  logic [2:0]      pulse_cnt, pulse_cnt_n;
  logic [2:0]      lvl_q;
  logic            dir_seed;
  logic            start_prev;
  logic            done_q, done_n;
  logic            load;
  logic [15:0]     rnd;

  logic            start_edge;
  logic [2:0]      lvl_n;
  logic            seed_n;
  logic [3:0]      count_sum, speed_sum;
  logic [2:0]      count_n, speed_n;
  logic            dir_n;

  lfsr16 #(
    .Seed (Seed),
    .Mask (LFSR_MASK)
  ) u_lfsr (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Q      (rnd)
  );

  assign start_edge = LevelStart & ~start_prev;

  // A start edge wins over everything, including the final GAP's Done.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pulse_cnt_n = pulse_cnt;
    done_n      = 1'b0;
    load        = 1'b0;
    if (start_edge) begin
      state_n = LOAD;
      idx_n   = '0;
      load    = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          state_n     = STROBE;
          pulse_cnt_n = PULSE_INIT;
        end
        STROBE: begin
          if (pulse_cnt == 3'd0) state_n = GAP;
          else                   pulse_cnt_n = pulse_cnt - 3'd1;
        end
        GAP: begin
          if (idx == LAST_LANE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = LOAD;
            idx_n   = idx + IdxW'(1);
            load    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Bus values are registered on the edge that enters LOAD, so on a fresh
  // start the incoming Level and LFSR MSB are used before they are latched.
  always_comb begin
    lvl_n     = start_edge ? Level : lvl_q;
    seed_n    = start_edge ? rnd[15] : dir_seed;
    count_sum = 4'd1 + {2'b00, lvl_n[2:1]} + {3'b000, rnd[0]};
    speed_sum = {1'b0, lvl_n} + 4'd1 + {3'b000, rnd[2]};
    count_n   = (count_sum > MAX_CARS4) ? MAX_CARS3 : count_sum[2:0];
    speed_n   = (speed_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : speed_sum[2:0];
    dir_n     = idx_n[0] ^ seed_n;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      idx        <= '0;
      pulse_cnt  <= '0;
      lvl_q      <= '0;
      dir_seed   <= 1'b0;
      start_prev <= 1'b0;
      done_q     <= 1'b0;
      Direction  <= 1'b0;
      CarType    <= '0;
      CarCount   <= '0;
      CarSpeed   <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pulse_cnt  <= pulse_cnt_n;
      start_prev <= LevelStart;
      done_q     <= done_n;
      if (start_edge) begin
        lvl_q    <= Level;
        dir_seed <= rnd[15];
      end
      if (load) begin
        Direction <= dir_n;
        CarType   <= rnd[4:3];
        CarCount  <= count_n;
        CarSpeed  <= speed_n;
      end
    end
  end

  always_comb begin
    SpawnEnable = '0;
    if (state == STROBE) SpawnEnable[idx] = 1'b1;
  end

  assign Busy     = (state != IDLE);
  assign Done     = done_q;
  assign DbgState = state;

endmodule

// File: tb/tb_lane_spawn_sequencer.sv
// Directed bench for lane_spawn_sequencer with a per-lane expected-config scoreboard.
module tb_lane_spawn_sequencer;
  import lane_spawn_pkg::*;

  localparam int          N    = 8;
  localparam int          PL   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         Clk = 1'b0;
  logic         ResetN = 1'b1;
  logic         LevelStart = 1'b0;
  logic [2:0]   Level = 3'd0;
  logic [N-1:0] SpawnEnable;
  logic         Direction;
  logic [1:0]   CarType;
  logic [2:0]   CarCount;
  logic [2:0]   CarSpeed;
  logic         Busy;
  logic         Done;
  state_t       DbgState;

  lane_spawn_sequencer #(
    .NumLanes (N),
    .PulseLen (PL),
    .Seed     (SEED),
    .MaxCars  (5)
  ) dut (
    .Clk         (Clk),
    .ResetN      (ResetN),
    .LevelStart  (LevelStart),
    .Level       (Level),
    .SpawnEnable (SpawnEnable),
    .Direction   (Direction),
    .CarType     (CarType),
    .CarCount    (CarCount),
    .CarSpeed    (CarSpeed),
    .Busy        (Busy),
    .Done        (Done),
    .DbgState    (DbgState)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int          total = 0;
  int          bad   = 0;
  logic [5:0]  exp_q[$];          // {level, lane} expected strobe order
  logic [15:0] m_lfsr;
  logic [15:0] hist[3];           // model LFSR value in this cycle and the two before
  logic [N-1:0] prev_se;
  logic [8:0]  prev_bus, snap_bus;
  logic        dir_seed_m;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    logic [15:0] r;
    r = q >> 1;
    if (q[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: pops an expected lane on each rising strobe and checks the buses
  task automatic monitor();
    logic [8:0]  bus;
    logic [5:0]  e;
    logic [2:0]  lane, lvl;
    logic [15:0] r;
    int          e_cnt, e_spd;
    bus = {Direction, CarType, CarCount, CarSpeed};
    chk("onehot0", 32'($onehot0(SpawnEnable)), 32'd1);
    if (SpawnEnable != '0 && prev_se == '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(SpawnEnable), 32'd0);
      end else begin
        e    = exp_q.pop_front();
        lane = e[2:0];
        lvl  = e[5:3];
        r    = hist[2];
        if (lane == 3'd0) dir_seed_m = r[15];
        e_cnt = 1 + int'(lvl[2:1]) + int'(r[0]);
        if (e_cnt > 5) e_cnt = 5;
        e_spd = int'(lvl) + 1 + int'(r[2]);
        if (e_spd > 7) e_spd = 7;
        chk($sformatf("strobe_lane%0d", lane), 32'(SpawnEnable), 32'(1) << lane);
        chk($sformatf("dir_lane%0d", lane), 32'(Direction), 32'(lane[0] ^ dir_seed_m));
        chk($sformatf("type_lane%0d", lane), 32'(CarType), 32'(r[4:3]));
        chk($sformatf("count_lane%0d", lane), 32'(CarCount), 32'(e_cnt));
        chk($sformatf("speed_lane%0d", lane), 32'(CarSpeed), 32'(e_spd));
        chk($sformatf("bus_setup_lane%0d", lane), 32'(bus), 32'(prev_bus));
      end
      snap_bus = bus;
    end else if (SpawnEnable != '0) begin
      chk("strobe_hold", 32'(SpawnEnable), 32'(prev_se));
      chk("bus_hold", 32'(bus), 32'(snap_bus));
    end
    if (SpawnEnable != '0) begin
      chk("count_range", 32'(CarCount >= 3'd1 && CarCount <= 3'd5), 32'd1);
      chk("speed_range", 32'(CarSpeed >= 3'd1), 32'd1);
    end
    prev_se  = SpawnEnable;
    prev_bus = bus;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!ResetN) m_lfsr = SEED;
    else         m_lfsr = lfsr_next(m_lfsr);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = m_lfsr;
    @(negedge Clk);
    monitor();
  endtask

  // driver: raise LevelStart for the accepting edge and queue the expected lanes
  task automatic start_seq(input logic [2:0] lvl, input bit hold);
    Level      = lvl;
    LevelStart = 1'b1;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back({lvl, 3'(k)});
    tick();
    if (!hold) LevelStart = 1'b0;
  endtask

  // called in cycle 1 after an accepted start edge
  task automatic check_timeline(input string tag);
    logic [N-1:0] e_se;
    int           p;
    for (int c = 1; c <= 34; c++) begin
      e_se = '0;
      p    = c - 2;
      if (p >= 0 && (p / (PL + 2)) < N && (p % (PL + 2)) < PL)
        e_se = N'(1) << (p / (PL + 2));
      chk($sformatf("%s_se_c%0d", tag, c), 32'(SpawnEnable), 32'(e_se));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(Busy), 32'(c <= 32));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(Done), 32'(c == 33));
      if (c < 34) tick();
    end
    chk($sformatf("%s_sb_drained", tag), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rl;
    m_lfsr     = SEED;
    hist[0]    = SEED;
    hist[1]    = SEED;
    hist[2]    = SEED;
    prev_se    = '0;
    prev_bus   = '0;
    snap_bus   = '0;
    dir_seed_m = 1'b0;

    // reset values
    #1 ResetN = 1'b0;
    repeat (3) tick();
    ResetN = 1'b1;
    chk("rst_se", 32'(SpawnEnable), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_count", 32'(CarCount), 32'd0);
    chk("rst_state", 32'(DbgState), 32'(IDLE));
    chk("rst_lfsr", 32'(dut.u_lfsr.Q), 32'(SEED));
    repeat (2) tick();

    // full sequences at level 0, level 7 (clamps) and a random level
    start_seq(3'd0, 1'b0);
    check_timeline("lvl0");
    repeat (3) tick();
    start_seq(3'd7, 1'b0);
    check_timeline("lvl7");
    repeat (2) tick();
    rl = 3'($urandom_range(1, 6));
    start_seq(rl, 1'b0);
    check_timeline("lvlrand");
    repeat (2) tick();

    // restart while lane 3 is strobing
    start_seq(3'd2, 1'b0);
    for (int i = 0; i < 40 && SpawnEnable != 8'h08; i++) tick();
    chk("wait_lane3", 32'(SpawnEnable), 32'h08);
    start_seq(3'd4, 1'b0);
    chk("restart_se_clear", 32'(SpawnEnable), 32'd0);
    chk("restart_load", 32'(DbgState), 32'(LOAD));
    check_timeline("restart");
    repeat (2) tick();

    // asynchronous reset while lane 5 is strobing
    start_seq(3'd1, 1'b0);
    for (int i = 0; i < 40 && SpawnEnable != 8'h20; i++) tick();
    chk("wait_lane5", 32'(SpawnEnable), 32'h20);
    #2 ResetN = 1'b0;
    #1;
    chk("arst_se", 32'(SpawnEnable), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    chk("arst_count", 32'(CarCount), 32'd0);
    exp_q.delete();
    m_lfsr = SEED;
    repeat (2) tick();
    ResetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("post_rst_idle_%0d", i), 32'({Busy, SpawnEnable}), 32'd0);
    end

    // LevelStart held high for 100 cycles: exactly one sequence
    start_seq(3'd5, 1'b1);
    check_timeline("hold");
    for (int i = 0; i < 66; i++) begin
      tick();
      chk($sformatf("hold_idle_%0d", i), 32'({Busy, Done, SpawnEnable}), 32'd0);
    end
    LevelStart = 1'b0;
    repeat (3) tick();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_spawn_sequencer.md
Name: lane_spawn_sequencer

Overview:
- Upstream configuration stage for the road lanes. On each level start it walks all lanes in order.
- For each lane it draws a pseudo-random, level-scaled configuration (direction, car type, count, speed) and presents it on shared buses.
- It then strobes that lane's SpawnEnable line. Each lane latches the shared buses on the rising edge of its own SpawnEnable.
- Data is guaranteed stable around every strobe.

Parameters:
- NumLanes, 8, number of lanes driven; SpawnEnable vector width.
- PulseLen, 2, Clk cycles each SpawnEnable bit stays high (1..7).
- Seed, 16'hACE1, LFSR reset value (must be nonzero).
- MaxCars, 5, upper clamp on CarCount (lane supports 1..5).

Ports:
- Clk  in  1  system clock.
- ResetN  in  1  asynchronous, active-low reset.
- LevelStart  in  1  start request; rising edge sampled on Clk.
- Level  in  3  difficulty level, latched on accepted start.
- SpawnEnable  out  NumLanes  per-lane spawn strobe, one-hot or zero.
- Direction  out  1  shared: 1 = cars face left.
- CarType  out  2  shared car sprite type.
- CarCount  out  3  shared cars in lane, 1..MaxCars.
- CarSpeed  out  3  shared speed, 1..7.
- Busy  out  1  high while a sequence is in progress.
- Done  out  1  one-cycle pulse when the last lane completes.

Behaviour:
- Reset (async, ResetN=0): all outputs 0, state IDLE, LFSR=Seed, lane index 0, LevelStart edge register 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances one step every Clk cycle while ResetN=1. rnd = LFSR value registered in the LOAD cycle.
- Start: LevelStart rising edge (current 1, previous 0) at a Clk edge.
  - Latch Level into LvlQ.
  - Latch DirSeed = LFSR[15].
  - Lane index = 0, go to LOAD.
  - Busy goes high next cycle.
- States: IDLE, LOAD, STROBE, GAP.
  - IDLE: all SpawnEnable 0. Shared buses hold their last values.
  - LOAD (1 cycle): update the shared buses from rnd:
    - Direction = laneIdx[0] ^ DirSeed.
    - CarType = rnd[4:3].
    - CarCount = min(1 + LvlQ[2:1] + rnd[0], MaxCars). Compute in 4 bits, then truncate.
    - CarSpeed = min(LvlQ + 1 + rnd[2], 7). Compute in 4 bits.
    - SpawnEnable stays 0, so data precedes the strobe by one cycle.
  - STROBE (PulseLen cycles): SpawnEnable[laneIdx]=1, all other bits 0. Buses held.
  - GAP (1 cycle): SpawnEnable all 0, buses held.
    - If laneIdx == NumLanes-1: go to IDLE, pulse Done for this one cycle of entry.
    - Else: laneIdx+1, go to LOAD.
- Timing, with start accepted at edge 0:
  - Lane k LOAD at cycle 1+k*(PulseLen+2).
  - Lane k strobe high for the following PulseLen cycles.
  - Default total 32 cycles; Busy high for cycles 1..32; Done high in cycle 33.
- Restart: a start edge accepted in any non-IDLE state aborts immediately.
  - SpawnEnable is 0 from the next cycle.
  - Sequence restarts at lane 0 with LOAD.
  - No Done pulse for the aborted sequence; Busy stays high.
- Simultaneous start edge and final GAP: the restart wins and Done is suppressed.
- LevelStart held high: only one start is accepted; no re-trigger until it goes low and high again.
- Mid-operation reset: outputs clear asynchronously. After release the block stays in IDLE until a new edge.
- Invariant: the shared buses never change while any SpawnEnable bit is 1, nor in the cycle before a rising SpawnEnable bit.

Decomposition:
- Package lane_spawn_pkg holds:
  - state enum (IDLE, LOAD, STROBE, GAP);
  - LFSR_MASK = 16'hB400;
  - MAX_SPEED = 3'd7;
  - the car-count clamp default.
- Sub-module lfsr16: parameters Seed and mask. Ports Clk, ResetN, Q[15:0]; free-running.

Test Plan:
- Reset values: hold ResetN=0 for 3 cycles, release → SpawnEnable=0, Busy=0, Done=0, CarCount=0, internal LFSR=16'hACE1.
- Full sequence at Level=0: one-cycle LevelStart → SpawnEnable[k] high exactly cycles 2+4k and 3+4k for k=0..7; CarCount ∈ {1,2}; CarSpeed ∈ {1,2}; Direction alternates between lanes; Busy cycles 1–32; Done pulse cycle 33 only.
- Level=7 clamp: start → every lane CarCount ∈ {4,5} and CarSpeed=7 exactly; no out-of-range value ever observed.
- Restart mid-run: second LevelStart edge while SpawnEnable[3] high → all SpawnEnable 0 next cycle, lane-0 LOAD follows, no Done for the first run, Done 32 cycles after restart.
- Async reset mid-strobe: drop ResetN during SpawnEnable[5] high (between Clk edges) → SpawnEnable and Busy go 0 without a Clk edge; no activity after release until a new LevelStart edge.
- Stability/held input: LevelStart held high for 100 cycles → exactly one sequence runs; scoreboard confirms buses constant from each LOAD through the end of its GAP.
